// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer:
// direction-counter encoding, saturating counter update and width helpers.
package btb_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;
  localparam ctr_t WNT = 2'd1;
  localparam ctr_t WT  = 2'd2;
  localparam ctr_t ST  = 2'd3;

  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    if (taken) return (ctr == ST)  ? ST  : ctr_t'(ctr + 2'd1);
    else       return (ctr == SNT) ? SNT : ctr_t'(ctr - 2'd1);
  endfunction

  // A direct-mapped configuration still carries a one-bit way/state field.
  function automatic int unsigned way_bits(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int unsigned plru_bits(input int unsigned ways);
    return (ways == 4) ? 3 : 1;
  endfunction

endpackage

// File: rtl/btb_set_assoc_plru.sv
// Per-set pseudo-LRU next-state and victim logic: a 1-bit LRU pointer for
// two ways, a 3-bit tree for four ways, nothing for a direct-mapped set.
module btb_plru
  import btb_pkg::*;
#(
  parameter int unsigned WAYS = 2,
  localparam int unsigned WAY_W  = way_bits(WAYS),
  localparam int unsigned PLRU_W = plru_bits(WAYS)
) (
  input  logic [PLRU_W-1:0] state,
  input  logic              touch_valid,
  input  logic [WAY_W-1:0]  touch_way,
  output logic [PLRU_W-1:0] state_next,
  output logic [WAY_W-1:0]  victim_way
);

  if (WAYS == 4) begin : g_tree
    // Bit 0 selects the LRU half, bits 1/2 the LRU way within ways 0-1 / 2-3.
    always_comb begin
      state_next = state;
      if (touch_valid) begin
        state_next[0] = ~touch_way[1];
        if (touch_way[1]) state_next[2] = ~touch_way[0];
        else              state_next[1] = ~touch_way[0];
      end
      victim_way = state[0] ? {1'b1, state[2]} : {1'b0, state[1]};
    end
  end else if (WAYS == 2) begin : g_pair
    always_comb begin
      state_next = touch_valid ? ~touch_way : state;
      victim_way = state;
    end
  end else begin : g_direct
    always_comb begin
      state_next = '0;
      victim_way = '0;
    end
  end

endmodule

// File: rtl/btb_set_assoc.sv
// Set-associative BTB with registered lookup, execute-side update, PLRU
// replacement and flush. Optional statistics counters via BTB_STATS_EN.
module btb_set_assoc
  import btb_pkg::*;
#(
  parameter int unsigned ENTRIES = 256,
  parameter int unsigned WAYS    = 2,
  parameter int unsigned PC_W    = 32
) (
  input  logic            btb_clk,
  input  logic            btb_reset_n,
  input  logic            btb_lookup_valid,
  input  logic [PC_W-1:0] btb_lookup_pc,
  output logic            btb_resp_valid,
  output logic            btb_hit,
  output logic            btb_predict_taken,
  output logic [PC_W-1:0] btb_target,
  input  logic            btb_upd_valid,
  input  logic [PC_W-1:0] btb_upd_pc,
  input  logic [PC_W-1:0] btb_upd_target,
  input  logic            btb_upd_taken,
`ifdef BTB_STATS_EN
  output logic [31:0]     btb_stat_lookups,
  output logic [31:0]     btb_stat_hits,
  output logic [31:0]     btb_stat_mispredicts,
`endif
  input  logic            btb_flush
);

  localparam int unsigned SETS   = ENTRIES / WAYS;
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = PC_W - 2 - IDX_W;
  localparam int unsigned WAY_W  = way_bits(WAYS);
  localparam int unsigned PLRU_W = plru_bits(WAYS);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    ctr_t             ctr;
  } entry_t;

  entry_t            mem   [SETS][WAYS];
  logic [WAYS-1:0]   valid [SETS];
  logic [PLRU_W-1:0] plru  [SETS];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, up_free;
  logic [WAY_W-1:0] lk_way, up_way, free_way, plru_victim, up_way_sel;
  entry_t           lk_entry, up_entry;
  logic             lk_touch, up_touch;
  logic [PLRU_W-1:0] lk_plru_next, up_plru_next;

  assign lk_idx = btb_lookup_pc[IDX_W+1:2];
  assign lk_tag = btb_lookup_pc[PC_W-1:IDX_W+2];
  assign up_idx = btb_upd_pc[IDX_W+1:2];
  assign up_tag = btb_upd_pc[PC_W-1:IDX_W+2];

  // Lowest matching way wins if several ways hold the same tag.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!lk_hit && valid[lk_idx][w] && mem[lk_idx][w].tag == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
    lk_entry = mem[lk_idx][lk_way];
  end

  always_comb begin
    up_hit   = 1'b0;
    up_way   = '0;
    up_free  = 1'b0;
    free_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!up_hit && valid[up_idx][w] && mem[up_idx][w].tag == up_tag) begin
        up_hit = 1'b1;
        up_way = WAY_W'(w);
      end
      if (!up_free && !valid[up_idx][w]) begin
        up_free  = 1'b1;
        free_way = WAY_W'(w);
      end
    end
    up_entry   = mem[up_idx][up_way];
    up_way_sel = up_hit ? up_way : (up_free ? free_way : plru_victim);
  end

  assign lk_touch = btb_lookup_valid && lk_hit;
  assign up_touch = btb_upd_valid && (up_hit || btb_upd_taken);

  btb_plru #(.WAYS(WAYS)) u_plru_lookup (
    .state      (plru[lk_idx]),
    .touch_valid(lk_touch),
    .touch_way  (lk_way),
    .state_next (lk_plru_next),
    .victim_way ()
  );

  btb_plru #(.WAYS(WAYS)) u_plru_update (
    .state      (plru[up_idx]),
    .touch_valid(up_touch),
    .touch_way  (up_way_sel),
    .state_next (up_plru_next),
    .victim_way (plru_victim)
  );

  // Update touch is written after the lookup touch so it wins on a shared set.
  always_ff @(posedge btb_clk or negedge btb_reset_n) begin
    if (!btb_reset_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        plru[s]  <= '0;
      end
    end else if (btb_flush) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        plru[s]  <= '0;
      end
    end else begin
      if (lk_touch) plru[lk_idx] <= lk_plru_next;
      if (up_touch) begin
        plru[up_idx]              <= up_plru_next;
        valid[up_idx][up_way_sel] <= 1'b1;
      end
    end
  end

  always_ff @(posedge btb_clk) begin
    if (up_touch && !btb_flush) begin
      if (up_hit) begin
        mem[up_idx][up_way].ctr <= ctr_next(up_entry.ctr, btb_upd_taken);
        if (btb_upd_taken) mem[up_idx][up_way].target <= btb_upd_target;
      end else begin
        mem[up_idx][up_way_sel] <= entry_t'{tag: up_tag, target: btb_upd_target, ctr: WT};
      end
    end
  end

  always_ff @(posedge btb_clk or negedge btb_reset_n) begin
    if (!btb_reset_n) begin
      btb_resp_valid    <= 1'b0;
      btb_hit           <= 1'b0;
      btb_predict_taken <= 1'b0;
      btb_target        <= '0;
    end else begin
      btb_resp_valid <= btb_lookup_valid;
      if (btb_lookup_valid) begin
        btb_hit           <= lk_hit;
        btb_predict_taken <= lk_hit && lk_entry.ctr[1];
        btb_target        <= lk_hit ? lk_entry.target : '0;
      end
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge btb_clk or negedge btb_reset_n) begin
    if (!btb_reset_n) begin
      btb_stat_lookups     <= '0;
      btb_stat_hits        <= '0;
      btb_stat_mispredicts <= '0;
    end else if (btb_flush) begin
      btb_stat_lookups     <= '0;
      btb_stat_hits        <= '0;
      btb_stat_mispredicts <= '0;
    end else begin
      if (btb_lookup_valid && btb_stat_lookups != '1)
        btb_stat_lookups <= btb_stat_lookups + 32'd1;
      if (lk_touch && btb_stat_hits != '1)
        btb_stat_hits <= btb_stat_hits + 32'd1;
      if (btb_upd_valid && ((up_hit && up_entry.ctr[1]) != btb_upd_taken)
          && btb_stat_mispredicts != '1)
        btb_stat_mispredicts <= btb_stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_set_assoc.sv
// Directed bench for btb_set_assoc (ENTRIES=8, WAYS=2): timestamp-LRU
// reference model checked every cycle, plus hand-computed spot checks.
module tb_btb_set_assoc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lk_v;
  logic [31:0] lk_pc;
  logic        up_v;
  logic [31:0] up_pc, up_tgt;
  logic        up_tk;
  logic        fl;
  logic        rv, hit, pt;
  logic [31:0] tgt;
`ifdef BTB_STATS_EN
  logic [31:0] st_lk, st_hit, st_mp;
`endif

  always #5 clk = ~clk;

  btb_set_assoc #(.ENTRIES(8), .WAYS(2), .PC_W(32)) dut (
    .btb_clk(clk), .btb_reset_n(rst_n),
    .btb_lookup_valid(lk_v), .btb_lookup_pc(lk_pc),
    .btb_resp_valid(rv), .btb_hit(hit), .btb_predict_taken(pt), .btb_target(tgt),
    .btb_upd_valid(up_v), .btb_upd_pc(up_pc), .btb_upd_target(up_tgt),
    .btb_upd_taken(up_tk),
`ifdef BTB_STATS_EN
    .btb_stat_lookups(st_lk), .btb_stat_hits(st_hit), .btb_stat_mispredicts(st_mp),
`endif
    .btb_flush(fl)
  );

  int tests = 0;
  int errors = 0;

  // Reference model: 4 sets x 2 ways, true LRU by last-use timestamp.
  bit          m_v   [4][2];
  logic [27:0] m_tag [4][2];
  logic [31:0] m_tgt [4][2];
  int          m_ctr [4][2];
  int          m_stamp [4][2];
  int          tick;
  logic        exp_rv, exp_hit, exp_pt;
  logic [31:0] exp_tgt;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++) begin
        m_v[s][w] = 1'b0;
        m_stamp[s][w] = 0;
      end
    tick = 0;
    exp_rv = 1'b0; exp_hit = 1'b0; exp_pt = 1'b0; exp_tgt = '0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model resp_valid", {31'd0, rv},  {31'd0, exp_rv});
      chk("model hit",        {31'd0, hit}, {31'd0, exp_hit});
      chk("model predict",    {31'd0, pt},  {31'd0, exp_pt});
      chk("model target",     tgt, exp_tgt);
    end
  end

  task automatic step(input logic lv, input logic [31:0] lpc,
                      input logic uv, input logic [31:0] upc,
                      input logic [31:0] utgt, input logic utk, input logic f);
    int ls, us, lw, uw, vic;
    logic n_rv, n_hit, n_pt;
    logic [31:0] n_tgt;
    @(negedge clk);
    lk_v = lv; lk_pc = lpc; up_v = uv; up_pc = upc; up_tgt = utgt; up_tk = utk; fl = f;
    ls = int'(lpc[3:2]); us = int'(upc[3:2]);
    lw = -1; uw = -1; vic = -1;
    for (int w = 0; w < 2; w++) begin
      if (lw < 0 && m_v[ls][w] && m_tag[ls][w] == lpc[31:4]) lw = w;
      if (uw < 0 && m_v[us][w] && m_tag[us][w] == upc[31:4]) uw = w;
      if (vic < 0 && !m_v[us][w]) vic = w;
    end
    if (vic < 0) vic = (m_stamp[us][1] < m_stamp[us][0]) ? 1 : 0;
    n_rv = lv; n_hit = exp_hit; n_pt = exp_pt; n_tgt = exp_tgt;
    if (lv) begin
      n_hit = (lw >= 0);
      n_pt  = n_hit && m_ctr[ls][lw] >= 2;
      n_tgt = n_hit ? m_tgt[ls][lw] : 32'd0;
    end
    if (f) begin
      for (int s = 0; s < 4; s++)
        for (int w = 0; w < 2; w++) begin
          m_v[s][w] = 1'b0;
          m_stamp[s][w] = 0;
        end
    end else begin
      if (lv && lw >= 0) m_stamp[ls][lw] = ++tick;
      if (uv && uw >= 0) begin
        m_ctr[us][uw] = utk ? ((m_ctr[us][uw] == 3) ? 3 : m_ctr[us][uw] + 1)
                            : ((m_ctr[us][uw] == 0) ? 0 : m_ctr[us][uw] - 1);
        if (utk) m_tgt[us][uw] = utgt;
        m_stamp[us][uw] = ++tick;
      end else if (uv && utk) begin
        m_v[us][vic] = 1'b1;
        m_tag[us][vic] = upc[31:4];
        m_tgt[us][vic] = utgt;
        m_ctr[us][vic] = 2;
        m_stamp[us][vic] = ++tick;
      end
    end
    @(posedge clk);
    #1;
    exp_rv = n_rv; exp_hit = n_hit; exp_pt = n_pt; exp_tgt = n_tgt;
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] t, input logic tk);
    step(1'b0, 32'd0, 1'b1, pc, t, tk, 1'b0);
  endtask

  task automatic expect_resp(input string name, input logic h, input logic p, input logic [31:0] t);
    chk({name, " resp_valid"}, {31'd0, rv}, 32'd1);
    chk({name, " hit"}, {31'd0, hit}, {31'd0, h});
    chk({name, " predict"}, {31'd0, pt}, {31'd0, p});
    chk({name, " target"}, tgt, t);
  endtask

  initial begin
    rst_n = 1'b0; lk_v = 1'b0; lk_pc = '0; up_v = 1'b0; up_pc = '0;
    up_tgt = '0; up_tk = 1'b0; fl = 1'b0;
    model_reset();
    #1;
    chk("reset resp_valid", {31'd0, rv}, 32'd0);
    chk("reset target", tgt, 32'd0);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    lookup(32'h100);            expect_resp("reset lookup", 1'b0, 1'b0, 32'h0);
    update(32'h40, 32'h80, 1'b1);
    lookup(32'h40);             expect_resp("allocate", 1'b1, 1'b1, 32'h80);

    update(32'h40, 32'h0, 1'b0);
    update(32'h40, 32'h0, 1'b0);
    lookup(32'h40);             expect_resp("ctr down", 1'b1, 1'b0, 32'h80);
    for (int i = 0; i < 4; i++) update(32'h40, 32'h84, 1'b1);
    update(32'h40, 32'h0, 1'b0);
    lookup(32'h40);             expect_resp("ctr sat", 1'b1, 1'b1, 32'h84);

    update(32'h00, 32'h300, 1'b1);
    update(32'h10, 32'h310, 1'b1);
    lookup(32'h00);
    update(32'h20, 32'h320, 1'b1);
    lookup(32'h00);             expect_resp("plru keep 00", 1'b1, 1'b1, 32'h300);
    lookup(32'h10);             expect_resp("plru evict 10", 1'b0, 1'b0, 32'h0);
    lookup(32'h20);             expect_resp("plru alloc 20", 1'b1, 1'b1, 32'h320);

    step(1'b1, 32'h44, 1'b1, 32'h44, 32'h500, 1'b1, 1'b0);
    expect_resp("rbw miss", 1'b0, 1'b0, 32'h0);
    lookup(32'h44);             expect_resp("rbw then hit", 1'b1, 1'b1, 32'h500);
    update(32'h44, 32'h999, 1'b0);
    lookup(32'h44);             expect_resp("nt keeps target", 1'b1, 1'b0, 32'h500);

    update(32'h0C, 32'h60C, 1'b1);
    update(32'h1C, 32'h61C, 1'b1);
    step(1'b1, 32'h0C, 1'b1, 32'h1C, 32'h71C, 1'b1, 1'b0);
    expect_resp("race lookup", 1'b1, 1'b1, 32'h60C);
    update(32'h2C, 32'h62C, 1'b1);
    lookup(32'h0C);             expect_resp("race evict 0C", 1'b0, 1'b0, 32'h0);
    lookup(32'h1C);             expect_resp("race keep 1C", 1'b1, 1'b1, 32'h71C);
    lookup(32'h2F);             expect_resp("pc low bits", 1'b1, 1'b1, 32'h62C);

    step(1'b0, 32'h0, 1'b1, 32'h48, 32'h800, 1'b1, 1'b1);
    lookup(32'h40);             expect_resp("flush 40", 1'b0, 1'b0, 32'h0);
    lookup(32'h48);             expect_resp("flush 48", 1'b0, 1'b0, 32'h0);
    lookup(32'h44);             expect_resp("flush 44", 1'b0, 1'b0, 32'h0);
`ifdef BTB_STATS_EN
    step(1'b0, 32'h0, 1'b1, 32'h48, 32'h800, 1'b1, 1'b1);
    chk("stats lookups", st_lk, 32'd0);
    chk("stats hits", st_hit, 32'd0);
    chk("stats mispredicts", st_mp, 32'd0);
`endif
    update(32'h48, 32'h880, 1'b1);
    lookup(32'h48);             expect_resp("post flush alloc", 1'b1, 1'b1, 32'h880);

    @(negedge clk);
    lk_v = 1'b1; lk_pc = 32'h48;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid reset hit", {31'd0, hit}, 32'd0);
    chk("mid reset target", tgt, 32'd0);
    lk_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lookup(32'h48);             expect_resp("after reset", 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
